uart_param_loader: RTL and testbench
====================================

UART_PARAM_LOADER -- requirements
Module: uart_param_loader

Interface
REQ-001 The block SHALL have parameter PARAM_BYTES, default 26, giving the number of payload bytes per frame (range 1..64).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum clk cycles allowed between consecutive frame bytes.
REQ-004 The block SHALL have parameter CHECKSUM_EN, default 1, which enables the trailing checksum byte (0 = no checksum byte in the frame).
REQ-005 The block SHALL have port clk, input, 1, the 100 MHz system clock; it is the block's only clock.
REQ-006 The block SHALL have port reset, input, 1, the reset; reset is asynchronous and active-high.
REQ-007 The block SHALL have port rx_data, input, 8, the received UART byte.
REQ-008 The block SHALL have port rx_valid, input, 1, a one-cycle pulse qualifying rx_data.
REQ-009 The block SHALL have port params, output, 8*PARAM_BYTES, the last committed payload, with the first received byte in the MSBs.
REQ-010 The block SHALL have port params_valid, output, 1, a one-cycle pulse on commit.
REQ-011 The block SHALL have port error, output, 1, a one-cycle pulse on a rejected frame.
REQ-012 The block SHALL have port error_code, output, 2, the cause of the last error: 0 none, 1 checksum, 2 timeout.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port tx_data, output, 8, the acknowledgement byte.
REQ-015 The block SHALL have port tx_send, output, 1, a one-cycle request to the UART transmitter.
REQ-016 The block SHALL have port tx_ready, input, 1, which is high when the transmitter can accept a byte.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, PAYLOAD and CHECK.
REQ-018 In IDLE, rx_valid with rx_data==SYNC_BYTE SHALL move to PAYLOAD with byte index 0; any other byte SHALL be ignored, with no error raised.
REQ-019 In PAYLOAD, each rx_valid SHALL write rx_data into the shadow buffer at byte PARAM_BYTES-1-index and add it into an 8-bit wrapping sum.
REQ-020 When the last payload byte arrives, the FSM SHALL go to CHECK if CHECKSUM_EN=1, or commit and return to IDLE if CHECKSUM_EN=0.
REQ-021 In CHECK, a received byte that makes (sum + byte) mod 256 equal to 0 SHALL commit the frame; otherwise the block SHALL flag a checksum error. In both cases the FSM SHALL return to IDLE.
REQ-022 On commit, params SHALL load from the shadow buffer and params_valid SHALL pulse, both in the cycle after the final byte's rx_valid (latency 1).
REQ-023 params SHALL change only on commit; a partial or rejected frame SHALL never alter params.
REQ-024 The idle timer SHALL reload on every rx_valid and count while in PAYLOAD or CHECK; at TIMEOUT_CYCLES without a byte, the block SHALL pulse error, set error_code=2 and return to IDLE.
REQ-025 If rx_valid coincides with timer expiry, the byte SHALL take priority and no timeout SHALL be raised.
REQ-026 A SYNC_BYTE value received in PAYLOAD or CHECK SHALL be treated as data, not as a restart.
REQ-027 Commit SHALL queue ACK 8'h06 and any error SHALL queue NAK 8'h15 in a one-entry pending register.
REQ-028 tx_send SHALL pulse for one cycle with tx_data valid when the pending register is full and tx_ready=1; the entry SHALL clear in that cycle.
REQ-029 A new ACK/NAK arriving while the pending register is full SHALL overwrite the pending entry, so that the latest outcome wins.
REQ-030 error_code SHALL hold until the next error or until a commit, which clears it to 0.

Reset
REQ-031 Asserting reset at any time, including mid-frame, SHALL immediately force state IDLE, params=0, params_valid=0, error=0, error_code=0, busy=0, tx_send=0, tx_data=0, sum=0, index=0, an empty pending register and a cleared timer.

Structure
REQ-032 Package uart_param_pkg SHALL hold the state enum, the error_code enum, and the ACK_BYTE/NAK_BYTE constants.
REQ-033 The idle timer SHALL be a sub-module named idle_timer with inputs clk, reset, enable and reload and output expired; its width SHALL be derived from TIMEOUT_CYCLES via $clog2.

Verification (PARAM_BYTES=4, TIMEOUT_CYCLES=1000, CHECKSUM_EN=1)
REQ-034 Stimulus A5 01 02 03 04 F6 -> params=32'h01020304, params_valid pulses once, tx_data=06 is sent.
REQ-035 Stimulus A5 01 02 03 04 00 -> error pulses, error_code=1, params is unchanged, tx_data=15 is sent.
REQ-036 Stimulus A5 01 02 followed by 1000 idle cycles -> error with error_code=2 after exactly 1000 cycles, the FSM returns to IDLE, then A5 11 22 33 44 56 commits 32'h11223344.
REQ-037 Stimulus 00 FF A5 A5 A5 A5 A5 6C -> the leading bytes are ignored and the frame commits 32'hA5A5A5A5.
REQ-038 Reset asserted after A5 01 02 -> all outputs go to 0 immediately; a subsequent full valid frame commits correctly.
REQ-039 tx_ready held low across a good frame followed by a bad frame -> only NAK 15 is sent once tx_ready rises.

Source files
------------

// File: rtl/uart_param_pkg.sv
// uart_param_pkg: shared state/error encodings and handshake bytes for the parameter loader.
package uart_param_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_CHECKSUM = 2'd1, ERR_TIMEOUT = 2'd2} err_t;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts enabled cycles since the last reload; expired flags TIMEOUT_CYCLES with no reload.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (reload || !enable) r_cnt <= '0;
    else if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  // a reload in the expiring cycle wins, so a late byte is never turned into a timeout
  assign expired = enable && !reload && (r_cnt == LAST);
endmodule

// File: rtl/uart_param_loader.sv
// uart_param_loader: receives sync/payload/checksum frames over UART, commits the payload
// atomically to params and answers each outcome with a single ACK/NAK byte.
module uart_param_loader
  import uart_param_pkg::*;
#(
  parameter int         PARAM_BYTES    = 26,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         CHECKSUM_EN    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [8*PARAM_BYTES-1:0] params,
  output logic                     params_valid,
  output logic                     error,
  output logic [1:0]               error_code,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  input  logic                     tx_ready
);
  localparam int PW = 8 * PARAM_BYTES;
  state_t            r_state, w_state_nx;
  err_t              r_err_code;
  logic [6:0]        r_idx;
  logic [7:0]        r_sum, w_sum_nx, r_pend;
  logic [PW-1:0]     r_shadow, w_shadow_nx;
  logic              r_pend_v, w_expired, w_commit, w_ck_err, w_to_err, w_err, w_last, w_wr, w_busy;

  assign w_busy = (r_state != S_IDLE);

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_busy),
    .reload  (rx_valid),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_commit    = 1'b0;
    w_ck_err    = 1'b0;
    w_to_err    = 1'b0;
    w_sum_nx    = r_sum + rx_data;
    w_last      = (r_idx == 7'(PARAM_BYTES - 1));
    w_wr        = (r_state == S_PAYLOAD) && rx_valid;
    w_shadow_nx = r_shadow;
    if (w_wr) w_shadow_nx[8*(PARAM_BYTES-1-int'(r_idx)) +: 8] = rx_data;
    case (r_state)
      S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) w_state_nx = S_PAYLOAD;
      S_PAYLOAD:
        if (rx_valid) begin
          if (w_last) begin
            w_state_nx = (CHECKSUM_EN != 0) ? S_CHECK : S_IDLE;
            w_commit   = (CHECKSUM_EN == 0);
          end
        end else if (w_expired) begin
          w_to_err   = 1'b1;
          w_state_nx = S_IDLE;
        end
      S_CHECK:
        if (rx_valid) begin
          w_commit   = (w_sum_nx == 8'd0);
          w_ck_err   = (w_sum_nx != 8'd0);
          w_state_nx = S_IDLE;
        end else if (w_expired) begin
          w_to_err   = 1'b1;
          w_state_nx = S_IDLE;
        end
      default: w_state_nx = S_IDLE;
    endcase
    w_err = w_ck_err || w_to_err;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_nx;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx        <= '0;
      r_sum        <= '0;
      r_shadow     <= '0;
      params       <= '0;
      params_valid <= 1'b0;
      error        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_pend_v     <= 1'b0;
      r_pend       <= '0;
    end else begin
      r_shadow     <= w_shadow_nx;
      r_idx        <= (r_state == S_IDLE) ? 7'd0 : w_wr ? r_idx + 7'd1 : r_idx;
      r_sum        <= (r_state == S_IDLE) ? 8'd0 : w_wr ? w_sum_nx : r_sum;
      params_valid <= w_commit;
      error        <= w_err;
      if (w_commit) params <= w_shadow_nx;
      r_err_code   <= w_commit ? ERR_NONE : w_ck_err ? ERR_CHECKSUM : w_to_err ? ERR_TIMEOUT : r_err_code;
      // a fresh outcome overwrites whatever is still waiting for the transmitter
      r_pend_v     <= (w_commit || w_err) ? 1'b1 : tx_send ? 1'b0 : r_pend_v;
      r_pend       <= w_commit ? ACK_BYTE : w_err ? NAK_BYTE : tx_send ? 8'd0 : r_pend;
    end

  assign tx_send    = r_pend_v && tx_ready;
  assign tx_data    = r_pend;
  assign busy       = w_busy;
  assign error_code = r_err_code;
endmodule

// File: tb/tb_uart_param_loader.sv
// tb_uart_param_loader: directed frames with a queue scoreboard checked by a negedge monitor.
module tb_uart_param_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] params;
  logic        params_valid, error, busy, tx_send, tx_ready;
  logic [1:0]  error_code;
  logic [7:0]  tx_data;
  int checks = 0;
  int failures = 0;
  logic [31:0] q_par[$];
  logic [1:0]  q_err[$];
  logic [7:0]  q_tx[$];

  uart_param_loader #(.PARAM_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(1000), .CHECKSUM_EN(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .params(params), .params_valid(params_valid), .error(error), .error_code(error_code),
    .busy(busy), .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rx_data  = v[8*i +: 8];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (params_valid) begin
        if (q_par.size() == 0) chk("params_valid_unexpected", {63'd0, params_valid}, 64'd0);
        else chk("params", {32'd0, params}, {32'd0, q_par.pop_front()});
      end
      if (error) begin
        if (q_err.size() == 0) chk("error_unexpected", {63'd0, error}, 64'd0);
        else chk("error_code", {62'd0, error_code}, {62'd0, q_err.pop_front()});
      end
      if (tx_send) begin
        if (q_tx.size() == 0) chk("tx_send_unexpected", {63'd0, tx_send}, 64'd0);
        else chk("tx_data", {56'd0, tx_data}, {56'd0, q_tx.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {18'd0, params, params_valid, error, error_code, busy, tx_send, tx_data}, 64'd0);
    reset = 1'b0;
    tick();
    // good frame
    q_par.push_back(32'h01020304); q_tx.push_back(8'h06);
    send_seq(64'hA501020304F6, 6);
    repeat (3) tick();
    chk("idle_after_good", {63'd0, busy}, 64'd0);
    // bad checksum
    q_err.push_back(2'd1); q_tx.push_back(8'h15);
    send_seq(64'hA50102030400, 6);
    repeat (3) tick();
    chk("params_kept_bad", {32'd0, params}, 64'h01020304);
    chk("err_code_checksum", {62'd0, error_code}, 64'd1);
    // timeout after partial frame
    q_err.push_back(2'd2); q_tx.push_back(8'h15);
    send_seq(64'hA50102, 3);
    repeat (999) tick();
    chk("no_early_timeout", {62'd0, error, busy}, 64'b01);
    tick();
    chk("timeout_at_1000", {61'd0, error, error_code}, 64'b110);
    tick();
    chk("idle_after_timeout", {63'd0, busy}, 64'd0);
    chk("params_kept_timeout", {32'd0, params}, 64'h01020304);
    q_par.push_back(32'h11223344); q_tx.push_back(8'h06);
    send_seq(64'hA51122334456, 6);
    repeat (3) tick();
    chk("err_code_cleared", {62'd0, error_code}, 64'd0);
    // leading junk ignored, sync value as data
    q_par.push_back(32'hA5A5A5A5); q_tx.push_back(8'h06);
    send_seq(64'h00FFA5A5A5A5A56C, 8);
    repeat (3) tick();
    chk("sync_as_data", {32'd0, params}, 64'hA5A5A5A5);
    // transmitter stalled: latest outcome (NAK) wins
    tx_ready = 1'b0;
    q_par.push_back(32'h01020304); q_err.push_back(2'd1); q_tx.push_back(8'h15);
    send_seq(64'hA501020304F6, 6);
    send_seq(64'hA50102030400, 6);
    repeat (4) tick();
    chk("pending_nak", {56'd0, tx_data}, 64'h15);
    tx_ready = 1'b1;
    repeat (3) tick();
    // async reset mid-frame
    send_seq(64'hA50102, 3);
    chk("busy_mid_frame", {63'd0, busy}, 64'd1);
    #3 reset = 1'b1;
    #1 chk("async_reset", {18'd0, params, params_valid, error, error_code, busy, tx_send, tx_data}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    q_par.push_back(32'h01020304); q_tx.push_back(8'h06);
    send_seq(64'hA501020304F6, 6);
    for (int i = 0; i < 50 && (q_par.size() + q_err.size() + q_tx.size()) != 0; i++) tick();
    repeat (3) tick();
    chk("params_queue_drained", 64'(q_par.size()), 64'd0);
    chk("error_queue_drained", 64'(q_err.size()), 64'd0);
    chk("tx_queue_drained", 64'(q_tx.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
